// File: rtl/mul_ctrl_pkg.sv
// Shared CPU multiply types: funct3 encodings, signedness classes, FSM states.
package mul_ctrl_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam int unsigned MUL_LATENCY = 67;

    typedef enum logic [1:0] {
        MT_UNSIGNED        = 2'd0,
        MT_SIGNED          = 2'd1,
        MT_SIGNED_UNSIGNED = 2'd2
    } mul_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN,
        S_RESP
    } mul_ctrl_state_e;

    typedef enum logic [1:0] {
        M_IDLE,
        M_RUN,
        M_DONE
    } mul_state_e;

    function automatic mul_type_e funct3_to_mul_type(input logic [2:0] f3);
        case (f3)
            F3_MULH:   return MT_SIGNED;
            F3_MULHSU: return MT_SIGNED_UNSIGNED;
            default:   return MT_UNSIGNED;
        endcase
    endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Request (reservation station) and response (CDB) channels of the multiply controller.
interface mul_ctrl_if #(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned TAG_WIDTH     = 5
);
    logic                     req_valid;
    logic                     req_ready;
    logic [2:0]               req_funct3;
    logic [OPERAND_WIDTH-1:0] req_rs1;
    logic [OPERAND_WIDTH-1:0] req_rs2;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [OPERAND_WIDTH-1:0] resp_data;
    logic [TAG_WIDTH-1:0]     resp_tag;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/mul_ctrl_shift_add_multiplier.sv
// Iterative shift-add multiplier: operands sign/zero-extended to 2W, 2W iterations,
// so one datapath serves all signedness classes. done rises 65 cycles after start.
module shift_add_multiplier
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  mul_type_e                  mul_type,
    input  logic [OPERAND_WIDTH-1:0]   a,
    input  logic [OPERAND_WIDTH-1:0]   b,
    output logic                       done,
    output logic [2*OPERAND_WIDTH-1:0] p
);
    localparam int unsigned PW = 2 * OPERAND_WIDTH;
    localparam int unsigned CW = $clog2(PW);

    mul_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   mcand_q;
    logic [PW-1:0]   mplier_q;
    logic [PW-1:0]   acc_q;
    logic            done_q;

    logic            sext_a;
    logic            sext_b;

    assign sext_a = (mul_type != MT_UNSIGNED) && a[OPERAND_WIDTH-1];
    assign sext_b = (mul_type == MT_SIGNED) && b[OPERAND_WIDTH-1];

    // DONE is held until start drops, so a still-high start cannot retrigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= M_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                M_IDLE: begin
                    if (start) begin
                        mcand_q  <= {{OPERAND_WIDTH{sext_a}}, a};
                        mplier_q <= {{OPERAND_WIDTH{sext_b}}, b};
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= M_RUN;
                    end
                end
                M_RUN: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(PW - 1)) begin
                        state_q <= M_DONE;
                        done_q  <= 1'b1;
                    end
                end
                M_DONE: begin
                    if (!start) begin
                        state_q <= M_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= M_IDLE;
            endcase
        end
    end

    assign done = done_q;
    assign p    = acc_q;

endmodule

// File: rtl/mul_ctrl.sv
// Multiply unit controller: accepts one op, runs the shift-add multiplier,
// holds the selected result half for the CDB, and handles flush/drain.
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned TAG_WIDTH     = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    mul_ctrl_if.slave bus
);
    localparam int unsigned PW = 2 * OPERAND_WIDTH;

    mul_ctrl_state_e          state_q;
    logic                     start_q;
    logic                     resp_valid_q;
    logic [OPERAND_WIDTH-1:0] rs1_q;
    logic [OPERAND_WIDTH-1:0] rs2_q;
    logic [TAG_WIDTH-1:0]     tag_q;
    logic [2:0]               funct3_q;
    mul_type_e                mul_type_q;
    logic [PW-1:0]            result_q;

    logic                     accept;
    logic                     mul_done;
    logic [PW-1:0]            mul_p;

    assign bus.req_ready = (state_q == S_IDLE) && !flush;
    assign accept        = bus.req_valid && bus.req_ready;

    // start_q tracks "next state is BUSY or DRAIN"; a flushed op still drains to done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            tag_q        <= '0;
            funct3_q     <= '0;
            mul_type_q   <= MT_UNSIGNED;
            result_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rs1_q      <= bus.req_rs1;
                        rs2_q      <= bus.req_rs2;
                        tag_q      <= bus.req_tag;
                        funct3_q   <= bus.req_funct3;
                        mul_type_q <= funct3_to_mul_type(bus.req_funct3);
                        start_q    <= 1'b1;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end else if (mul_done) begin
                        result_q     <= mul_p;
                        start_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    if (mul_done) begin
                        start_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (flush || bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_tag   = tag_q;
    assign bus.resp_data  = (funct3_q == F3_MUL) ? result_q[OPERAND_WIDTH-1:0]
                                                 : result_q[PW-1:OPERAND_WIDTH];

    shift_add_multiplier #(
        .OPERAND_WIDTH (OPERAND_WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst      (!rst),
        .start    (start_q),
        .mul_type (mul_type_q),
        .a        (rs1_q),
        .b        (rs2_q),
        .done     (mul_done),
        .p        (mul_p)
    );

endmodule
